uart_sample_pacer: RTL and testbench

//   Buffers 8-bit audio bytes arriving in bursts from the UART receiver and releases them
//   to the FM NCO stage at a fixed audio sample rate. This removes host/UART timing jitter

---
 rtl/uart_sample_pacer.sv | 103 ++++++++++
 tb/tb_uart_sample_pacer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_pacer.sv
// Elastic byte FIFO that paces bursty UART audio bytes out at a fixed sample rate.
// Prefills before playback and emits midscale silence on underrun.
module uart_sample_pacer #(
    parameter int          CLK_HZ      = 250_000_000,
    parameter int          SAMPLE_HZ   = 8_000,
    parameter int          ADDR_W      = 8,
    parameter int          PREFILL     = 128,
    parameter logic [7:0]  IDLE_SAMPLE = 8'h80
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_dat,
    input  logic              i_dat_vld,
    output logic [7:0]        o_sample,
    output logic              o_sample_stb,
    output logic [ADDR_W:0]   o_level,
    output logic              o_underrun,
    output logic              o_overflow,
    output logic              o_dbg_state
);

    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  PREFILL_L = (ADDR_W + 1)'(PREFILL);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                tick;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q;
    logic                push, pop;
    logic [7:0]          mem [DEPTH];
    logic [7:0]          head_q;

    // Input has no backpressure: i_dat_vld is a one-cycle push request that is either
    // written this cycle or dropped (flagged via o_overflow); there is no ready.
    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        pop      = tick && (state_q == ST_PLAY) && (level_q != '0);
        push     = i_dat_vld && ((level_q != DEPTH_L) || pop);
        rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (level_q >= PREFILL_L) state_d = ST_PLAY;
            ST_PLAY: if (tick && (level_q == '0)) state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_FILL;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            o_sample     <= IDLE_SAMPLE;
            o_sample_stb <= 1'b0;
            o_underrun   <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            cnt_q    <= tick ? '0 : cnt_q + CNT_W'(1);
            rd_ptr_q <= rd_ptr_d;
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (ADDR_W + 1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W + 1)'(1);
                default: level_q <= level_q;
            endcase
            o_sample_stb <= tick;
            o_underrun   <= tick && (state_q == ST_PLAY) && (level_q == '0);
            if (tick) o_sample <= pop ? head_q : IDLE_SAMPLE;
            if (i_dat_vld && !push) o_overflow <= 1'b1;
        end
    end

    // Registered read always prefetches the entry that will be head next cycle; a write
    // landing on that slot is forwarded so a freshly pushed byte is ready at the tick.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= i_dat;
        head_q <= (push && (wr_ptr_q == rd_ptr_d)) ? i_dat : mem[rd_ptr_d];
    end

    assign o_level     = level_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_sample_pacer.sv
// Scoreboarded bench for uart_sample_pacer: DIV=10, DEPTH=8, PREFILL=4.
// Expected {underrun, sample} pairs are queued as stimulus is driven and popped on each strobe.
module tb_uart_sample_pacer;

  localparam int ADDR_W = 3;
  localparam int DIV    = 10;
  localparam logic ST_FILL = 1'b0;
  localparam logic ST_PLAY = 1'b1;

  logic              clk;
  logic              i_rst;
  logic [7:0]        i_dat;
  logic              i_dat_vld;
  logic [7:0]        o_sample;
  logic              o_sample_stb;
  logic [ADDR_W:0]   o_level;
  logic              o_underrun;
  logic              o_overflow;
  logic              o_dbg_state;

  logic [8:0]        exp_q[$];
  int                n_vectors;
  int                n_errors;
  int                cyc;
  int                next_stb;

  uart_sample_pacer #(
    .CLK_HZ      (1000),
    .SAMPLE_HZ   (100),
    .ADDR_W      (ADDR_W),
    .PREFILL     (4),
    .IDLE_SAMPLE (8'h80)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_dat        (i_dat),
    .i_dat_vld    (i_dat_vld),
    .o_sample     (o_sample),
    .o_sample_stb (o_sample_stb),
    .o_level      (o_level),
    .o_underrun   (o_underrun),
    .o_overflow   (o_overflow),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard monitor: every strobe consumes one expected {underrun, sample}
  always @(negedge clk) begin
    if (o_sample_stb) begin
      if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
      else                   check("sample", 32'({o_underrun, o_sample}), 32'(exp_q.pop_front()));
      check("stb_cycle", 32'(cyc), 32'(next_stb));
      next_stb = cyc + DIV;
    end else begin
      check("underrun_idle", 32'(o_underrun), 32'd0);
    end
  end

  // driver tasks: all called on a falling edge and return on a falling edge
  task automatic exp_push(input logic u, input logic [7:0] s);
    exp_q.push_back({u, s});
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    i_dat_vld = 1'b0;
    @(negedge clk);
    i_rst    = 1'b0;
    exp_q.delete();
    next_stb = cyc + DIV;
    check("rst_level",    32'(o_level),      32'd0);
    check("rst_sample",   32'(o_sample),     32'h80);
    check("rst_stb",      32'(o_sample_stb), 32'd0);
    check("rst_underrun", 32'(o_underrun),   32'd0);
    check("rst_overflow", 32'(o_overflow),   32'd0);
    check("rst_state",    32'(o_dbg_state),  32'(ST_FILL));
  endtask

  task automatic push_byte(input logic [7:0] b);
    i_dat     = b;
    i_dat_vld = 1'b1;
    @(negedge clk);
    i_dat_vld = 1'b0;
  endtask

  task automatic wait_stb();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_sample_stb && k < 4 * DIV);
    check("stb_timeout", 32'(o_sample_stb), 32'd1);
  endtask

  task automatic wait_stbs(input int n);
    for (int i = 0; i < n; i++) wait_stb();
  endtask

  initial begin
    n_vectors = 0;
    n_errors  = 0;
    i_rst     = 1'b1;
    i_dat     = 8'h00;
    i_dat_vld = 1'b0;

    // 1: idle after reset, silence every DIV cycles
    do_reset();
    for (int i = 0; i < 3; i++) exp_push(1'b0, 8'h80);
    wait_stbs(3);
    check("t1_level", 32'(o_level), 32'd0);

    // 2: prefill four bytes right after a strobe; they play on the next four strobes
    exp_push(1'b0, 8'h10); exp_push(1'b0, 8'h20);
    exp_push(1'b0, 8'h30); exp_push(1'b0, 8'h40);
    for (int i = 1; i <= 4; i++) push_byte(8'(i * 16));
    check("t2_level4", 32'(o_level), 32'd4);
    @(negedge clk);
    check("t2_play", 32'(o_dbg_state), 32'(ST_PLAY));
    wait_stbs(4);
    check("t2_level0", 32'(o_level), 32'd0);

    // 3: underrun strobe, then below-prefill bytes keep silence
    exp_push(1'b1, 8'h80);
    wait_stbs(1);
    check("t3_fill", 32'(o_dbg_state), 32'(ST_FILL));
    exp_push(1'b0, 8'h80); exp_push(1'b0, 8'h80);
    for (int i = 0; i < 3; i++) push_byte(8'hA1 + 8'(i));
    check("t3_level3", 32'(o_level), 32'd3);
    wait_stbs(2);
    check("t3_still_fill", 32'(o_dbg_state), 32'(ST_FILL));
    check("t3_level_hold", 32'(o_level), 32'd3);

    // 4: nine bytes into an empty FIFO, last one dropped
    do_reset();
    exp_push(1'b0, 8'h80);
    wait_stb();
    for (int i = 1; i <= 8; i++) exp_push(1'b0, 8'(i));
    exp_push(1'b1, 8'h80);
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    check("t4_level8", 32'(o_level), 32'd8);
    check("t4_overflow", 32'(o_overflow), 32'd1);
    wait_stbs(9);
    check("t4_overflow_sticky", 32'(o_overflow), 32'd1);
    check("t4_level0", 32'(o_level), 32'd0);

    // 5: full FIFO in PLAY, push coincident with the tick is accepted
    do_reset();
    exp_push(1'b0, 8'h80);
    wait_stb();
    for (int i = 0; i < 9; i++) exp_push(1'b0, 8'hB0 + 8'(i));
    exp_push(1'b1, 8'h80);
    for (int i = 0; i < 8; i++) push_byte(8'hB0 + 8'(i));
    @(negedge clk);
    push_byte(8'hB8);
    check("t5_level8", 32'(o_level), 32'd8);
    check("t5_no_overflow", 32'(o_overflow), 32'd0);
    // the strobe carrying B0 is high on this very edge
    check("t5_stb_now", 32'(o_sample_stb), 32'd1);
    wait_stbs(9);
    check("t5_fill", 32'(o_dbg_state), 32'(ST_FILL));

    // 6: reset mid-PLAY with five bytes queued
    exp_push(1'b0, 8'hC0);
    for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
    wait_stb();
    check("t6_level5", 32'(o_level), 32'd5);
    check("t6_play", 32'(o_dbg_state), 32'(ST_PLAY));
    do_reset();
    exp_push(1'b0, 8'h80);
    wait_stb();
    check("t6_level_after", 32'(o_level), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
    $finish;
  end

endmodule
